// File: rtl/mux_stream_arbiter_if.sv
// Stream bundle between N producers and one consumer for mux_stream_arbiter.
// The slave modport is the arbiter's view; master is the producer/consumer side.
interface mux_stream_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned SelW = $clog2(N);

  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*W-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [SelW-1:0] out_sel;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );
endinterface

// File: rtl/mux_stream_arbiter.sv
// N-channel valid/ready stream mux with one registered output stage.
// Define MUX_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module mux_stream_arbiter #(
  parameter int unsigned N      = 4,
  parameter int unsigned W      = 8,
  parameter bit          INVERT = 1'b0
) (
  input logic                clk,
  input logic                rst,
  mux_stream_arbiter_if.slave bus
);
  localparam int unsigned SelW = $clog2(N);

  logic            any_valid;
  logic            load_ok;
  logic            accept;
  logic [SelW-1:0] grant;
  logic [W-1:0]    sel_data;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SelW-1:0] out_sel_q, out_sel_d;

`ifdef MUX_ARB_RR_EN
  logic [SelW-1:0] ptr_q, ptr_d;
`endif

  // Lowest valid index overall, then overridden by the lowest valid index at or above ptr.
  always_comb begin
    grant     = '0;
    any_valid = |bus.in_valid;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) grant = SelW'(i);
    end
`ifdef MUX_ARB_RR_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i] && (SelW'(i) >= ptr_q)) grant = SelW'(i);
    end
`endif
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SelW'(i)) sel_data = bus.in_data[i*W +: W];
    end
  end

  assign load_ok = !out_valid_q || bus.out_ready;
  assign accept  = any_valid && load_ok && !rst;

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_ready[i] = accept && (grant == SelW'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = INVERT ? ~sel_data : sel_data;
      out_sel_d   = grant;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef MUX_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (grant == SelW'(N - 1)) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_stream_arbiter.sv
// Bench for mux_stream_arbiter: plain and inverting instances share one stimulus.
// Follows MUX_ARB_RR_EN to pick round-robin or fixed-priority expectations.
module tb_mux_stream_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [W-1:0]   din [N];
  logic [N*W-1:0] in_data;
  logic           out_ready;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = din[k];
  end

  mux_stream_arbiter_if #(.N(N), .W(W)) bus0 ();
  mux_stream_arbiter_if #(.N(N), .W(W)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;

  mux_stream_arbiter #(.N(N), .W(W), .INVERT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mux_stream_arbiter #(.N(N), .W(W), .INVERT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: holding register contents plus a scan-from-pointer search.
  logic         m_valid;
  logic [W-1:0] m_data, m_data_inv;
  int           m_sel = 0;
  int           m_ptr = 0;
  int           eg;
  logic [N-1:0] exp_ready;

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always_comb begin
    eg        = pick(in_valid, m_ptr);
    exp_ready = '0;
    if (eg >= 0 && (!m_valid || out_ready) && !rst) exp_ready[eg] = 1'b1;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_data_inv <= '0;
      m_sel      <= 0;
      m_ptr      <= 0;
    end else if (exp_ready != '0) begin
      m_valid    <= 1'b1;
      m_data     <= din[eg];
      m_data_inv <= ~din[eg];
      m_sel      <= eg;
`ifdef MUX_ARB_RR_EN
      m_ptr      <= (eg + 1) % N;
`endif
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp out_valid0", bus0.out_valid, m_valid);
      chk("cmp out_valid1", bus1.out_valid, m_valid);
      chk("cmp out_data0", bus0.out_data, m_data);
      chk("cmp out_data1", bus1.out_data, m_data_inv);
      chk("cmp out_sel0", bus0.out_sel, m_sel);
      chk("cmp out_sel1", bus1.out_sel, m_sel);
      chk("cmp in_ready0", bus0.in_ready, exp_ready);
      chk("cmp in_ready1", bus1.in_ready, exp_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int es;
    logic [N-1:0] r;
`ifdef MUX_ARB_RR_EN
    int rr_sel [4] = '{1, 2, 3, 0};
`endif

    // Reset with every channel requesting.
    rst       = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    din       = '{8'h10, 8'h20, 8'h30, 8'h40};
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst out_valid", bus0.out_valid, 1'b0);
    chk("rst out_data0", bus0.out_data, 8'h00);
    chk("rst out_data1", bus1.out_data, 8'h00);
    chk("rst out_sel", bus0.out_sel, 2'd0);
    chk("rst in_ready", bus0.in_ready, 4'b0000);

    rst = 1'b0;
    tick();
    chk("first sel", bus0.out_sel, 2'd0);
    chk("first data0", bus0.out_data, 8'h10);
    chk("first data1", bus1.out_data, 8'hEF);
    chk("first valid", bus0.out_valid, 1'b1);

    // Fairness or fixed priority with all channels valid.
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef MUX_ARB_RR_EN
      es = rr_sel[i];
`else
      es = 0;
`endif
      chk("seq sel", bus0.out_sel, es);
      chk("seq data", bus0.out_data, 8'h10 * (es + 1));
    end

    in_valid = 4'b1110;
    tick();
    chk("drop ch0 sel", bus0.out_sel, 2'd1);
    chk("drop ch0 data", bus0.out_data, 8'h20);

    // Drain, then backpressure on a beat from channel 2.
    in_valid = 4'b0000;
    tick();
    chk("drain valid", bus0.out_valid, 1'b0);
    chk("drain data held", bus0.out_data, 8'h20);
    din[2]   = 8'hA5;
    in_valid = 4'b0100;
    tick();
    chk("bp load data", bus0.out_data, 8'hA5);
    chk("bp load sel", bus0.out_sel, 2'd2);
    out_ready = 1'b0;
    din[0]    = 8'h5A;
    in_valid  = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp hold data", bus0.out_data, 8'hA5);
      chk("bp hold sel", bus0.out_sel, 2'd2);
      chk("bp hold valid", bus0.out_valid, 1'b1);
      chk("bp in_ready", bus0.in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", bus0.in_ready, 4'b0001);
    tick();
    chk("bp reload data", bus0.out_data, 8'h5A);
    chk("bp reload sel", bus0.out_sel, 2'd0);
    chk("bp reload valid", bus0.out_valid, 1'b1);

    // Inversion.
    din[1]   = 8'h3C;
    in_valid = 4'b0010;
    tick();
    chk("inv ch1 data1", bus1.out_data, 8'hC3);
    chk("inv ch1 sel1", bus1.out_sel, 2'd1);
    chk("inv ch1 data0", bus0.out_data, 8'h3C);
    din[3]   = 8'h00;
    in_valid = 4'b1000;
    tick();
    chk("inv ch3 data1", bus1.out_data, 8'hFF);
    chk("inv ch3 sel1", bus1.out_sel, 2'd3);

    // Reset while a stalled beat is held.
    din[0]   = 8'h55;
    in_valid = 4'b0001;
    tick();
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    tick();
    chk("mid held data", bus0.out_data, 8'h55);
    chk("mid held valid", bus0.out_valid, 1'b1);
    rst      = 1'b1;
    in_valid = 4'b1111;
    din      = '{8'h10, 8'h20, 8'h30, 8'h40};
    tick();
    chk("mid rst valid", bus0.out_valid, 1'b0);
    chk("mid rst data", bus0.out_data, 8'h00);
    chk("mid rst sel", bus0.out_sel, 2'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("mid post sel", bus0.out_sel, 2'd0);
    chk("mid post data", bus0.out_data, 8'h10);

    // Mixed traffic obeying the producer rules, checked by the model every cycle.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      r = bus0.in_ready;
      tick();
      for (int k = 0; k < N; k++) begin
        if (r[k]) in_valid[k] = 1'b0;
        if (!in_valid[k] && ($urandom_range(0, 1) == 1)) begin
          in_valid[k] = 1'b1;
          din[k]      = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_stream_arbiter.md
# mux_stream_arbiter

Parametrised N-channel stream multiplexer with a registered output stage, valid/ready handshakes on every channel and round-robin or fixed-priority channel selection. It generalises the two-input combinational mux into a sequential selector that merges several producer streams into one consumer stream. An optional per-instance bitwise inversion of the forwarded data gives the NOT-via-mux behaviour at stream level. It sits between multiple producer blocks and a single shared consumer.

## Interface

- N, default 4: number of input channels; legal range 2..16.
- W, default 8: data width per channel; legal range ≥1.
- INVERT, default 0: 1 forwards ~data, 0 forwards data unchanged.
- SELW, derived, $clog2(N): width of the channel index.

- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel valid; bit k belongs to channel k.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- in_data  input  N*W  channel k occupies bits [k*W +: W].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  W  registered data of the held beat.
- out_sel  output  SELW  registered index of the channel that produced the held beat.

## Operation

- A transfer occurs on any interface when valid and ready are both high at a rising edge.
- State:
  - output register holding out_valid, out_data and out_sel;
  - priority pointer ptr (SELW bits), used only in round-robin mode.
- The output register can load when `load_ok = !out_valid || out_ready`.
- Grant (combinational):
  - Search channels starting at ptr (round-robin) or at 0 (fixed priority).
  - The first channel with in_valid=1 is granted; index wraps from N-1 to 0.
- in_ready[g] = load_ok for the granted channel g; all other bits are 0.
  - If no in_valid bit is high, in_ready is all zeros.
- On a transfer from channel g:
  - out_data ← INVERT ? ~in_data[g] : in_data[g];
  - out_sel ← g;
  - out_valid ← 1;
  - ptr ← (g == N-1) ? 0 : g+1.
- Output drains with no new input (out_valid && out_ready and no granted input): out_valid ← 0. out_data and out_sel hold their last values.
- Output drains and a new input is accepted in the same cycle: the register reloads and out_valid stays 1. Full throughput is one beat per cycle.
- Output stall (out_valid && !out_ready):
  - all in_ready bits are 0;
  - out_data and out_sel are held stable;
  - ptr does not move.
- ptr changes only on an accepted input transfer.
- Data ordering within a channel is preserved. Channels are never merged or dropped.
- Producers may raise in_valid at any time and must keep it and in_data stable until accepted. in_ready may depend combinationally on in_valid; producers must not make in_valid depend on in_ready.

## Timing

- Latency: an input accepted at edge t appears on out_data/out_valid immediately after edge t. This is one register stage.
- Throughput: one beat per cycle while out_ready=1 and any channel is valid.
- Fairness (round-robin): with all N channels continuously valid and out_ready=1, the grant sequence is 0,1,…,N-1,0,… Each channel waits at most N-1 transfers.
- Reset (rst high at an edge):
  - out_valid=0, out_data=0, out_sel=0, ptr=0;
  - in_ready is all zeros during the reset cycle.
- Reset mid-transfer: a beat held in the output register is discarded, and any simultaneous input handshake is ignored. Reset has priority over all other updates.
- No combinational path from in_data to out_data. The only combinational paths are in_valid→in_ready and out_ready→in_ready.

## Configuration

- MUX_ARB_RR_EN defined: round-robin selection; the ptr register exists and updates as above.
- MUX_ARB_RR_EN undefined: fixed priority, lowest index wins. ptr is not implemented, so a continuously valid channel 0 can starve the others.
- The interface and all other behaviour are identical in both builds.

## Test plan

1. Reset and idle (N=4, W=8):
   - rst high for 2 cycles with all in_valid=1 → out_valid=0, out_data=0x00, out_sel=0, in_ready=4'b0000.
   - After release, with out_ready=1, the first beat comes from channel 0.
2. Round-robin fairness (MUX_ARB_RR_EN):
   - All channels valid with data 0x10,0x20,0x30,0x40 and out_ready=1 → out_sel sequence 0,1,2,3,0; out_data 0x10,0x20,0x30,0x40,0x10 on consecutive cycles.
3. Fixed priority (macro undefined), same stimulus:
   - out_sel stays 0 every cycle.
   - Dropping in_valid[0] makes out_sel=1 on the next transfer.
4. Backpressure:
   - Beat 0xA5 from channel 2 held with out_ready=0 for 5 cycles → out_data=0xA5 and out_sel=2 stable, in_ready=0 throughout.
   - When out_ready rises, the next beat loads in that same cycle.
5. Inversion (INVERT=1):
   - Channel 1 sends 0x3C → out_data=0xC3, out_sel=1.
   - Channel 3 sends 0x00 → out_data=0xFF.
6. Reset mid-stream:
   - rst asserted while out_valid=1 with beat 0x55 and out_ready=0 → next cycle out_valid=0, out_data=0x00, ptr=0.
   - After release, the first grant goes to channel 0.
